// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the instruction-side sequencer: opcode names, FSM states,
// instruction field positions and the decoded control word.
package ctrl_sequencer_pkg;

  localparam int INSTR_W = 9;
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 5;
  localparam int RA_MSB  = 4;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 1;
  localparam int IM_MSB  = 2;
  localparam int IM_LSB  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_GEQ  = 4'h7,
    OP_EQ   = 4'h8,
    OP_NEQ  = 4'h9,
    OP_BNZL = 4'hA,
    OP_BNZR = 4'hB,
    OP_LD   = 4'hC,
    OP_ST   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } op_mne;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEMWAIT,
    DONE
  } ctrl_state_t;

  // The IR resets to a NOP so nothing downstream sees a stale write or branch.
  localparam logic [INSTR_W-1:0] NOP_INSTR = {4'hE, 5'b00000};

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] alu_im;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       is_halt;
    logic       br_left;
    logic       br_right;
  } ctrl_word_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= 4'hB);
  endfunction

  // Compares write their 0/1 result to Ra; only the two branches leave the RF alone.
  function automatic logic alu_writes_rf(input logic [3:0] op);
    return is_alu_op(op) && (op != OP_BNZL) && (op != OP_BNZR);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_inst_decode.sv
// Combinational decode of the instruction register into the sequencer control word.
module inst_decode
  import ctrl_sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output ctrl_word_t         o_ctrl
);

  logic [3:0] w_op;

  assign w_op = i_ir[OP_MSB:OP_LSB];

  always_comb begin
    o_ctrl          = '0;
    o_ctrl.ra       = i_ir[RA_MSB:RA_LSB];
    o_ctrl.rb       = i_ir[RB_MSB:RB_LSB];
    o_ctrl.alu_im   = i_ir[IM_MSB:IM_LSB];
    o_ctrl.alu_op   = is_alu_op(w_op) ? w_op : 4'h0;
    o_ctrl.reg_wr   = alu_writes_rf(w_op);
    o_ctrl.mem_rd   = (w_op == OP_LD);
    o_ctrl.mem_wr   = (w_op == OP_ST);
    o_ctrl.is_halt  = (w_op == OP_HALT);
    o_ctrl.br_left  = (w_op == OP_BNZL);
    o_ctrl.br_right = (w_op == OP_BNZR);
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/exec sequencer: fetches 9-bit instructions, drives ALU/RF/memory
// controls with registered strobes, steers the PC on branches and guards each run with a watchdog.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MAX_CYCLES = 65535
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req,
  output logic               o_ack,
  output logic               o_err,
  output logic [PC_W-1:0]    o_inst_addr,
  input  logic [INSTR_W-1:0] i_instruction,
  output logic [1:0]         o_ra_addr,
  output logic [1:0]         o_rb_addr,
  output logic               o_reg_wr_en,
  output logic               o_wr_sel_mem,
  output logic [3:0]         o_alu_op,
  output logic [2:0]         o_alu_im,
  input  logic               i_branch,
  input  logic [7:0]         i_br_offset,
  output logic               o_mem_rd_en,
  output logic               o_mem_wr_en,
  output logic [15:0]        o_inst_count
);

  localparam int CYC_W = $clog2(MAX_CYCLES + 1);

  ctrl_state_t        r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_pc;
  logic [15:0]        r_inst_count;
  logic [CYC_W-1:0]   r_cyc;
  logic               r_ack;
  logic               r_err;
  logic               r_reg_wr;
  logic               r_wr_sel;
  logic               r_mem_rd;
  logic               r_mem_wr;

  ctrl_word_t         w_ctrl;
  logic [PC_W-1:0]    w_offset;
  logic [PC_W-1:0]    w_pc_next;
  logic [15:0]        w_count_next;
  logic               w_wd_expired;

  inst_decode u_decode (
    .i_ir   (r_ir),
    .o_ctrl (w_ctrl)
  );

  assign w_offset     = PC_W'(i_br_offset);
  assign w_count_next = (r_inst_count == 16'hFFFF) ? r_inst_count : r_inst_count + 16'd1;
  // r_cyc holds the number of the current cycle since leaving IDLE (first running cycle = 1).
  assign w_wd_expired = (r_cyc >= CYC_W'(MAX_CYCLES));

  // PC arithmetic wraps naturally at PC_W bits; offset 0 with a taken branch re-executes itself.
  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_ctrl.br_left && i_branch) begin
      w_pc_next = r_pc - w_offset;
    end else if (w_ctrl.br_right && i_branch) begin
      w_pc_next = r_pc + w_offset;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_pc         <= PC_W'(START_ADDR);
      r_ir         <= NOP_INSTR;
      r_inst_count <= '0;
      r_cyc        <= '0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_reg_wr     <= 1'b0;
      r_wr_sel     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_reg_wr <= 1'b0;
      r_wr_sel <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_pc         <= PC_W'(START_ADDR);
          r_inst_count <= '0;
          r_cyc        <= '0;
          r_ack        <= 1'b0;
          r_err        <= 1'b0;
          if (i_req) begin
            r_state <= FETCH;
            r_cyc   <= CYC_W'(1);
          end
        end
        FETCH: begin
          if (w_wd_expired) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_ir    <= i_instruction;
            r_cyc   <= r_cyc + CYC_W'(1);
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_wd_expired) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cyc    <= r_cyc + CYC_W'(1);
            r_reg_wr <= w_ctrl.reg_wr;
            r_mem_rd <= w_ctrl.mem_rd;
            r_mem_wr <= w_ctrl.mem_wr;
            if (w_ctrl.mem_rd) begin
              r_state <= MEMWAIT;
            end else begin
              r_pc         <= w_pc_next;
              r_inst_count <= w_count_next;
              if (w_ctrl.is_halt) begin
                r_state <= DONE;
                r_ack   <= 1'b1;
              end else begin
                r_state <= FETCH;
              end
            end
          end
        end
        MEMWAIT: begin
          // Load data arrives from the synchronous memory one cycle after the read strobe.
          if (w_wd_expired) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cyc        <= r_cyc + CYC_W'(1);
            r_reg_wr     <= 1'b1;
            r_wr_sel     <= 1'b1;
            r_pc         <= w_pc_next;
            r_inst_count <= w_count_next;
            r_state      <= FETCH;
          end
        end
        DONE: begin
          if (!i_req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_err        = r_err;
  assign o_inst_addr  = r_pc;
  assign o_ra_addr    = w_ctrl.ra;
  assign o_rb_addr    = w_ctrl.rb;
  assign o_reg_wr_en  = r_reg_wr;
  assign o_wr_sel_mem = r_wr_sel;
  assign o_alu_op     = w_ctrl.alu_op;
  assign o_alu_im     = w_ctrl.alu_im;
  assign o_mem_rd_en  = r_mem_rd;
  assign o_mem_wr_en  = r_mem_wr;
  assign o_inst_count = r_inst_count;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: strobe scoreboard, PC trace and a small-watchdog instance.
module tb_ctrl_sequencer;

  localparam logic [8:0] I_NOP  = 9'b1110_00000;
  localparam logic [8:0] I_HALT = 9'b1111_00000;

  typedef struct {
    logic [2:0] vec;
    int         cyc;
    logic [1:0] ra;
    logic       ws;
    logic [3:0] op;
    logic [2:0] im;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req;
  logic       branch;
  logic [7:0] br_off;
  logic [8:0] rom [0:1023];
  logic [8:0] instruction;
  logic       ack, err, reg_wr_en, wr_sel_mem, mem_rd_en, mem_wr_en;
  logic [9:0] inst_addr;
  logic [1:0] ra_addr, rb_addr;
  logic [3:0] alu_op;
  logic [2:0] alu_im;
  logic [15:0] inst_count;

  logic       wd_req;
  logic       wd_ack, wd_err, wd_reg_wr_en, wd_wr_sel_mem, wd_mem_rd_en, wd_mem_wr_en;
  logic [9:0] wd_inst_addr;
  logic [1:0] wd_ra_addr, wd_rb_addr;
  logic [3:0] wd_alu_op;
  logic [2:0] wd_alu_im;
  logic [15:0] wd_inst_count;

  assign instruction = rom[inst_addr];

  ctrl_sequencer u_dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .o_ack(ack), .o_err(err),
    .o_inst_addr(inst_addr), .i_instruction(instruction),
    .o_ra_addr(ra_addr), .o_rb_addr(rb_addr), .o_reg_wr_en(reg_wr_en),
    .o_wr_sel_mem(wr_sel_mem), .o_alu_op(alu_op), .o_alu_im(alu_im),
    .i_branch(branch), .i_br_offset(br_off), .o_mem_rd_en(mem_rd_en),
    .o_mem_wr_en(mem_wr_en), .o_inst_count(inst_count)
  );

  // Every ROM word is BNZR R0 with offset 0: a branch-to-self loop only the watchdog can end.
  ctrl_sequencer #(.MAX_CYCLES(20)) u_wd (
    .i_clk(clk), .i_reset(rst), .i_req(wd_req), .o_ack(wd_ack), .o_err(wd_err),
    .o_inst_addr(wd_inst_addr), .i_instruction(9'b1011_00000),
    .o_ra_addr(wd_ra_addr), .o_rb_addr(wd_rb_addr), .o_reg_wr_en(wd_reg_wr_en),
    .o_wr_sel_mem(wd_wr_sel_mem), .o_alu_op(wd_alu_op), .o_alu_im(wd_alu_im),
    .i_branch(1'b1), .i_br_offset(8'd0), .o_mem_rd_en(wd_mem_rd_en),
    .o_mem_wr_en(wd_mem_wr_en), .o_inst_count(wd_inst_count)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  ev_t  sb_q[$];
  int   addr_q[$];
  bit   track_addr = 1'b0;
  bit   loop_mode = 1'b0;
  int   visits = 0;
  int   last_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [2:0] vec, input int c, input logic [1:0] ra,
                         input logic ws, input logic [3:0] op, input logic [2:0] im);
    ev_t e;
    e.vec = vec; e.cyc = c; e.ra = ra; e.ws = ws; e.op = op; e.im = im;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    ev_t        e;
    logic [2:0] w;
    int         ea;
    @(posedge clk);
    #1;
    cyc++;
    if (int'(inst_addr) != last_addr) begin
      if (track_addr) begin
        if (addr_q.size() == 0) chk("addr_extra", 32'(inst_addr), 32'(last_addr));
        else begin
          ea = addr_q.pop_front();
          chk("inst_addr_seq", 32'(inst_addr), 32'(ea));
        end
      end
      if (loop_mode && inst_addr == 10'd5) visits++;
      last_addr = int'(inst_addr);
    end
    branch = loop_mode && (visits <= 3);
    w = {reg_wr_en, mem_rd_en, mem_wr_en};
    if (w != 3'b000) begin
      if (sb_q.size() == 0) chk("spurious_strobe", 32'(w), 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("strobe_kind", 32'(w), 32'(e.vec));
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("strobe_ra", 32'(ra_addr), 32'(e.ra));
        chk("strobe_wrsel", 32'(wr_sel_mem), 32'(e.ws));
        chk("strobe_aluop", 32'(alu_op), 32'(e.op));
        chk("strobe_aluim", 32'(alu_im), 32'(e.im));
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
  endtask

  task automatic start_run();
    req = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to_ack(input int budget, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack) begin
        ack_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic end_run(input string tag);
    chk({tag, "_missing_strobe"}, 32'(sb_q.size()), 32'd0);
    req = 1'b0;
    tick();
    chk({tag, "_ack_fall"}, 32'(ack), 32'd0);
  endtask

  initial begin
    int ack_cyc;
    rst = 1'b1; req = 1'b0; wd_req = 1'b0; branch = 1'b0; br_off = 8'd0;
    clear_rom();
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pc", 32'(inst_addr), 32'd0);
    chk("rst_enables", 32'({reg_wr_en, wr_sel_mem, mem_rd_en, mem_wr_en}), 32'd0);
    chk("rst_aluop_im", 32'({alu_op, alu_im}), 32'd0);
    chk("rst_count", 32'(inst_count), 32'd0);
    rst = 1'b0;
    tick();

    // Lone HALT: Ack three cycles after Req, one retired instruction, no writes.
    rom[0] = I_HALT;
    start_run();
    run_to_ack(20, ack_cyc);
    chk("halt_ack_cycle", 32'(ack_cyc), 32'd3);
    chk("halt_err", 32'(err), 32'd0);
    chk("halt_count", 32'(inst_count), 32'd1);
    tick(); tick();
    chk("done_hold_ack", 32'(ack), 32'd1);
    end_run("halt");

    // ADDI R1,5 ; ADD R1,R1 ; HALT
    clear_rom();
    rom[0] = 9'b0001_01_101;
    rom[1] = 9'b0000_01_01_0;
    rom[2] = I_HALT;
    push_ev(3'b100, 3, 2'd1, 1'b0, 4'h1, 3'd5);
    push_ev(3'b100, 5, 2'd1, 1'b0, 4'h0, 3'd2);
    start_run();
    run_to_ack(30, ack_cyc);
    chk("alu_ack_cycle", 32'(ack_cyc), 32'd7);
    chk("alu_count", 32'(inst_count), 32'd3);
    end_run("alu");

    // LD R2,[R0] ; HALT
    clear_rom();
    rom[0] = 9'b1100_10_00_0;
    rom[1] = I_HALT;
    push_ev(3'b010, 3, 2'd2, 1'b0, 4'h0, 3'd0);
    push_ev(3'b100, 4, 2'd2, 1'b1, 4'h0, 3'd0);
    start_run();
    run_to_ack(30, ack_cyc);
    chk("ld_ack_cycle", 32'(ack_cyc), 32'd6);
    chk("ld_count", 32'(inst_count), 32'd2);
    end_run("ld");

    // NOP x5, BNZL at 5 (offset 1, taken three times), HALT at 6.
    clear_rom();
    rom[5] = 9'b1010_00_00_0;
    rom[6] = I_HALT;
    br_off = 8'd1; loop_mode = 1'b1; visits = 0; last_addr = 0;
    addr_q = '{1, 2, 3, 4, 5, 4, 5, 4, 5, 4, 5, 6, 7};
    track_addr = 1'b1;
    start_run();
    run_to_ack(80, ack_cyc);
    track_addr = 1'b0; loop_mode = 1'b0; branch = 1'b0; br_off = 8'd0;
    chk("loop_ack_cycle", 32'(ack_cyc), 32'd27);
    chk("loop_count", 32'(inst_count), 32'd13);
    chk("loop_addr_left", 32'(addr_q.size()), 32'd0);
    end_run("loop");

    // Watchdog with MAX_CYCLES=20 on a branch-to-self loop.
    wd_req = 1'b1;
    cyc = 0;
    ack_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wd_ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    chk("wd_ack_cycle", 32'(ack_cyc), 32'd21);
    chk("wd_err", 32'(wd_err), 32'd1);
    chk("wd_count", 32'(wd_inst_count), 32'd9);
    chk("wd_pc_self", 32'(wd_inst_addr), 32'd0);
    wd_req = 1'b0;
    tick();
    chk("wd_ack_fall", 32'(wd_ack), 32'd0);
    chk("wd_err_fall", 32'(wd_err), 32'd0);

    // ST R1,[R2] interrupted by reset in EXEC, then rerun cleanly.
    clear_rom();
    rom[0] = 9'b1101_01_10_0;
    rom[1] = I_HALT;
    start_run();
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_memwr", 32'(mem_wr_en), 32'd0);
    chk("rst_mid_pc", 32'(inst_addr), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    chk("rst_mid_aluop", 32'(alu_op), 32'd0);
    tick();
    chk("rst_mid_memwr_hold", 32'(mem_wr_en), 32'd0);
    rst = 1'b0;
    push_ev(3'b001, 3, 2'd1, 1'b0, 4'h0, 3'd4);
    start_run();
    run_to_ack(30, ack_cyc);
    chk("st_ack_cycle", 32'(ack_cyc), 32'd5);
    chk("st_count", 32'(inst_count), 32'd2);
    end_run("st");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
